// File: rtl/fir_freq_meter.sv
// Zero-crossing period/peak meter for the filtered FIR output, measured in f_s sample ticks.
// Optional peak tracking is enabled by defining FREQ_METER_PEAK_EN; otherwise peak reads 0.
module fir_freq_meter #(
  parameter int HYST    = 64,
  parameter int TIMEOUT = 4000,
  parameter int PW      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               f_s,
  input  logic signed [11:0] din,
  output logic [PW-1:0]      period,
  output logic [10:0]        peak,
  output logic               valid,
  output logic               locked,
  output logic               timeout
);

  typedef enum logic [1:0] {INIT_LO, INIT_HI, LO, HI} state_t;

  localparam logic signed [11:0] POS_TH = 12'(HYST);
  localparam logic signed [11:0] NEG_TH = -POS_TH;
  localparam logic [PW-1:0]      TO_CNT = PW'(TIMEOUT);

  state_t        state, next_state;
  logic          f_s_q, tick;
  logic [PW-1:0] cnt, cnt_inc;
  logic          lo_hit, hi_hit, counting;
  logic          start, publish, expire;

  assign tick     = f_s & ~f_s_q;
  assign lo_hit   = din <= NEG_TH;
  assign hi_hit   = din >= POS_TH;
  assign cnt_inc  = cnt + PW'(1);
  assign counting = (state == LO) || (state == HI);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INIT_LO;
      f_s_q <= 1'b0;
    end else begin
      state <= next_state;
      f_s_q <= f_s;
    end
  end

  // A publish on the HI crossing takes priority over an expiring counter.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    publish    = 1'b0;
    expire     = 1'b0;
    if (tick) begin
      case (state)
        INIT_LO: if (lo_hit) next_state = INIT_HI;
        INIT_HI: begin
          if (hi_hit) begin
            start      = 1'b1;
            next_state = LO;
          end
        end
        LO: begin
          if (cnt_inc == TO_CNT) begin
            expire     = 1'b1;
            next_state = INIT_LO;
          end else if (lo_hit) begin
            next_state = HI;
          end
        end
        HI: begin
          if (hi_hit) begin
            publish    = 1'b1;
            next_state = LO;
          end else if (cnt_inc == TO_CNT) begin
            expire     = 1'b1;
            next_state = INIT_LO;
          end
        end
        default: next_state = INIT_LO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      period  <= '0;
      valid   <= 1'b0;
      locked  <= 1'b0;
      timeout <= 1'b0;
    end else begin
      valid <= publish;
      if (start || publish || expire) begin
        cnt <= '0;
      end else if (tick && counting) begin
        cnt <= cnt_inc;
      end
      if (publish) begin
        period  <= cnt_inc;
        locked  <= 1'b1;
        timeout <= 1'b0;
      end else if (expire) begin
        locked  <= 1'b0;
        timeout <= 1'b1;
      end
    end
  end

`ifdef FREQ_METER_PEAK_EN
  logic [10:0] mag, pk, pk_max;

  // -2048 has no positive 12-bit counterpart, so it saturates to 2047.
  always_comb begin
    mag = din[10:0];
    if (din[11]) begin
      if (din[10:0] == 11'd0) mag = 11'h7FF;
      else                    mag = 11'(~din[10:0] + 11'd1);
    end
  end

  assign pk_max = (mag > pk) ? mag : pk;

  // The crossing sample seeds the next period as well as closing the current one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pk   <= '0;
      peak <= '0;
    end else begin
      if (start || publish) begin
        pk <= mag;
      end else if (tick && counting) begin
        pk <= pk_max;
      end
      if (publish) peak <= pk_max;
    end
  end
`else
  assign peak = '0;
`endif

endmodule

// File: doc/fir_freq_meter.md
# fir_freq_meter

Tone/frequency meter that sits directly downstream of the FIR low-pass stage and consumes its filtered 12-bit signed output at the f_s sample rate. It detects positive-going zero crossings with hysteresis and measures the period between them in sample ticks. It also reports the peak magnitude seen in each period. The results characterise filter passband and stopband behaviour in the DSP chain, for example checking the 200 Hz tone after rejection of the 1.6 kHz and 2 kHz components.

## Interface
- HYST, 64: hysteresis threshold in LSBs; a crossing requires din <= -HYST, then din >= +HYST.
- TIMEOUT, 4000: maximum tick count per period before lock is declared lost; must be < 2^PW.
- PW, 16: width of the period counter and output.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- f_s  in  1  sample clock (slow, clk-synchronous level signal); each rising edge is one sample tick.
- din  in  12  signed two's-complement sample (FIR_LPF dout).
- period  out  PW  ticks between the last two positive crossings.
- peak  out  11  max |din| over the last measured period, saturated.
- valid  out  1  one-clk pulse when period/peak update.
- locked  out  1  at least one period measured since reset/timeout.
- timeout  out  1  sticky: period exceeded TIMEOUT.

## Operation
- Tick detect: f_s_q <= f_s each clk; tick = f_s & ~f_s_q. All processing happens only on tick cycles; din is ignored otherwise.
- FSM states:
  - INIT_LO: wait for din <= -HYST, then go to INIT_HI.
  - INIT_HI: wait for din >= +HYST. On hit, set cnt <= 0 and pk <= |din|, then go to LO.
  - LO: wait for din <= -HYST, then go to HI.
  - HI: wait for din >= +HYST. On hit, publish and return to LO.
- Counting: in LO/HI, each tick sets cnt <= cnt+1 and pk <= max(pk, |din|).
- Publish, on the HI crossing tick:
  - period <= cnt+1, peak <= max(pk, |din|).
  - valid pulse, locked <= 1, timeout <= 0.
  - cnt <= 0, pk <= |din| of the crossing sample (that sample belongs to both periods).
- |din| saturates: -2048 gives 2047. Result is 11-bit unsigned.
- Timeout: in LO/HI, a tick where cnt+1 == TIMEOUT and no publish occurs causes:
  - timeout <= 1, locked <= 0, state <= INIT_LO, cnt <= 0.
  - No valid; period and peak hold their old values.
- INIT states never time out.
- A publish and a timeout on the same tick: the publish wins.
- A sample satisfying both thresholds cannot occur for HYST > 0. HYST = 0 is illegal.

## Timing
- Reset (rst low, asynchronous): state INIT_LO; cnt, pk, f_s_q = 0; period = 0, peak = 0, valid = 0, locked = 0, timeout = 0.
- Reset mid-measurement discards the partial period. After release, the first valid requires two fresh positive crossings.
- Tick is recognised on the clk edge at which f_s = 1 and f_s_q = 0. din is sampled on that edge.
- period, peak, locked and timeout update on that same edge. valid is high for exactly the one following clk cycle.
- Latency: one clk from the qualifying f_s rising edge being registered to outputs visible.
- f_s held constant: no ticks, outputs frozen, valid low.
- At most one tick per two clk cycles (f_s high and low each at least one clk).

## Configuration
- FREQ_METER_PEAK_EN defined: peak tracking as above.
- Not defined: pk logic and abs/saturation removed, peak tied to 0. period, valid, locked and timeout are unchanged.

## Test plan
- Square wave, din = +500 for 25 ticks then -500 for 25 ticks, repeated:
  - valid every 50 ticks with period = 50, peak = 500 (PEAK_EN).
  - locked = 1 from the first valid, which occurs at the second positive crossing.
- Hysteresis rejection, din toggling ±40 each tick with HYST = 64, for 10000 ticks:
  - No valid, locked = 0, timeout = 0.
- Timeout recovery:
  - After lock at period 50, hold din = +300. Exactly 4000 ticks after the last crossing, timeout = 1, locked = 0, no valid, period holds 50.
  - Restart the 50-tick wave: first new valid after two crossings, with timeout = 0 and locked = 1.
- Peak saturation: one sample of -2048 inside a 50-tick period -> peak = 2047 at the next valid. Without the macro, peak = 0.
- Reset mid-period: pulse rst low in state HI -> all outputs 0 immediately, and no valid until two new positive crossings complete.
- Gated ticks: hold f_s high for 1000 clk while din swings ±1000 every clk -> no state change, no valid.
